// File: rtl/button_event_ctrl.sv
// Debounced button event controller: per-button debounce, PRESS/RELEASE events, round-robin event output.
// Define BTN_EVT_REPEAT_EN to build the per-button hold FSM that adds LONG and REPEAT events.
//
// Hold FSM (per button, only with BTN_EVT_REPEAT_EN):
//   state    | meaning
//   H_IDLE   | button released, no hold timing
//   H_HELD   | pressed, counting down to the LONG event
//   H_LONGED | LONG issued, counting down to each REPEAT event
module button_event_ctrl #(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 100000,
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 500,
  parameter int REP_TICKS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [2:0]       evt_btn,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] btn_level,
  output logic             overflow
);

  localparam int TDIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(N_BTN - 1);
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;

  logic [N_BTN-1:0]  sync_q1, sync_q2;
  logic [TDIV_W-1:0] tdiv_cnt;
  logic              tick;

  logic [DEB_W-1:0]  deb_cnt   [N_BTN];
  logic [DEB_W-1:0]  deb_cnt_d [N_BTN];
  logic [N_BTN-1:0]  level_d;
  logic [N_BTN-1:0]  post_vld;
  logic [1:0]        post_type [N_BTN];

  logic [N_BTN-1:0]  pend_vld;
  logic [1:0]        pend_type [N_BTN];
  logic [2:0]        rr_ptr;
  logic              load;
  logic              grant_any;
  logic [2:0]        grant_idx;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;
  localparam int HOLD_MAX = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] LONG_LOAD = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LOAD  = HOLD_W'(REP_TICKS - 1);

  typedef enum logic [1:0] {H_IDLE, H_HELD, H_LONGED} hold_t;
  hold_t             hold_q     [N_BTN];
  hold_t             hold_d     [N_BTN];
  logic [HOLD_W-1:0] hold_cnt   [N_BTN];
  logic [HOLD_W-1:0] hold_cnt_d [N_BTN];
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (LONG_TICKS > 0) ^ (REP_TICKS > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      tdiv_cnt <= '0;
    end else begin
      sync_q1  <= btn_raw;
      sync_q2  <= sync_q1;
      tdiv_cnt <= tick ? TDIV_LAST : tdiv_cnt - TDIV_W'(1);
    end
  end

  assign tick = (tdiv_cnt == '0);

  // A level flip has priority over a hold event in the same tick.
  always_comb begin
    level_d  = btn_level;
    post_vld = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = deb_cnt[i];
      post_type[i] = EVT_PRESS;
`ifdef BTN_EVT_REPEAT_EN
      hold_d[i]     = hold_q[i];
      hold_cnt_d[i] = hold_cnt[i];
`endif
      if (tick) begin
        if (sync_q2[i] != btn_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level_d[i]   = sync_q2[i];
            deb_cnt_d[i] = '0;
            post_vld[i]  = 1'b1;
            post_type[i] = sync_q2[i] ? EVT_PRESS : EVT_RELEASE;
          end else begin
            deb_cnt_d[i] = deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
`ifdef BTN_EVT_REPEAT_EN
        if (post_vld[i]) begin
          if (sync_q2[i]) begin
            hold_d[i]     = H_HELD;
            hold_cnt_d[i] = LONG_LOAD;
          end else begin
            hold_d[i]     = H_IDLE;
            hold_cnt_d[i] = '0;
          end
        end else begin
          case (hold_q[i])
            H_HELD: begin
              if (hold_cnt[i] == '0) begin
                post_vld[i]   = 1'b1;
                post_type[i]  = EVT_LONG;
                hold_d[i]     = H_LONGED;
                hold_cnt_d[i] = REP_LOAD;
              end else begin
                hold_cnt_d[i] = hold_cnt[i] - HOLD_W'(1);
              end
            end
            H_LONGED: begin
              if (hold_cnt[i] == '0) begin
                post_vld[i]   = 1'b1;
                post_type[i]  = EVT_REPEAT;
                hold_cnt_d[i] = REP_LOAD;
              end else begin
                hold_cnt_d[i] = hold_cnt[i] - HOLD_W'(1);
              end
            end
            default: ;
          endcase
        end
`endif
      end
    end
  end

  // Round-robin search begins at rr_ptr, which points one past the last grant.
  always_comb begin
    int cand;
    cand      = 0;
    load      = !evt_valid || evt_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    if (load) begin
      for (int k = 0; k < N_BTN; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= N_BTN) cand = cand - N_BTN;
        if (!grant_any && pend_vld[cand]) begin
          grant_any = 1'b1;
          grant_idx = 3'(cand);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      pend_vld  <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= '0;
      overflow  <= 1'b0;
      rr_ptr    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i]   <= '0;
        pend_type[i] <= '0;
      end
    end else begin
      btn_level <= level_d;
      if (load) begin
        evt_valid <= grant_any;
        if (grant_any) begin
          evt_btn  <= grant_idx;
          evt_type <= pend_type[grant_idx];
          rr_ptr   <= (grant_idx == LAST_IDX) ? 3'd0 : grant_idx + 3'd1;
        end
      end
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= deb_cnt_d[i];
        // A slot being granted this cycle is free for a new event.
        if (post_vld[i]) begin
          if (pend_vld[i] && !(grant_any && grant_idx == 3'(i))) begin
            overflow <= 1'b1;
          end else begin
            pend_vld[i]  <= 1'b1;
            pend_type[i] <= post_type[i];
          end
        end else if (grant_any && grant_idx == 3'(i)) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

`ifdef BTN_EVT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i]   <= H_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i]   <= hold_d[i];
        hold_cnt[i] <= hold_cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button/ready/reset traffic,
// every cycle compared against a tick-level behavioural model of the event rules.
module tb_button_event_ctrl;
  localparam int N    = 5;
  localparam int TDIV = 4;
  localparam int DEB  = 3;
  localparam int LONG = 8;
  localparam int REP  = 4;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic         evt_ready;
  logic         evt_valid;
  logic [2:0]   evt_btn;
  logic [1:0]   evt_type;
  logic [N-1:0] btn_level;
  logic         overflow;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN(N), .TICK_DIV(TDIV), .DEB_TICKS(DEB), .LONG_TICKS(LONG), .REP_TICKS(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_btn(evt_btn), .evt_type(evt_type),
    .btn_level(btn_level), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt [8][4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: edges counted since reset, raw delayed two samples, events per tick.
  logic [N-1:0] m_d1 = '0, m_d2 = '0, m_level = '0;
  int  m_n = 0, m_btn = 0, m_type = 0, m_rr = 0;
  int  m_run [N], m_held [N], m_pt [N];
  bit  m_pv [N];
  bit  m_vld = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin : model
    logic [N-1:0] synced;
    bit tick;
    int g, idx, post;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_n = 0;
      m_vld = 1'b0; m_btn = 0; m_type = 0; m_rr = 0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_held[i] = -1; m_pv[i] = 1'b0; m_pt[i] = 0;
      end
    end else begin
      synced = m_d2;
      m_d2   = m_d1;
      m_d1   = btn_raw;
      tick   = (m_n % TDIV) == 0;
      m_n++;
      if (!m_vld || evt_ready) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && m_pv[idx]) g = idx;
        end
        m_vld = (g >= 0);
        if (g >= 0) begin
          m_btn = g; m_type = m_pt[g]; m_pv[g] = 1'b0; m_rr = (g + 1) % N;
        end
      end
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          post = -1;
          if (synced[i] != m_level[i]) begin
            if (m_run[i] + 1 == DEB) begin
              m_level[i] = synced[i];
              m_run[i]   = 0;
              post       = synced[i] ? 0 : 1;
              m_held[i]  = synced[i] ? 0 : -1;
            end else begin
              m_run[i]++;
            end
          end else begin
            m_run[i] = 0;
          end
          if (post < 0 && REP_EN && m_held[i] >= 0) begin
            m_held[i]++;
            if (m_held[i] == LONG) post = 2;
            else if (m_held[i] > LONG && (m_held[i] - LONG) % REP == 0) post = 3;
          end
          if (post >= 0) begin
            if (m_pv[i]) m_ovf = 1'b1;
            else begin m_pv[i] = 1'b1; m_pt[i] = post; end
          end
        end
      end
    end
  end

  // Inputs are already driven for the coming edge; log the handshake, then check after it.
  task automatic step_cyc();
    if (!rst && evt_valid && evt_ready) acc_cnt[evt_btn][evt_type]++;
    @(negedge clk);
    check_val("evt_valid", evt_valid, m_vld);
    if (m_vld) begin
      check_val("evt_btn", evt_btn, m_btn);
      check_val("evt_type", evt_type, m_type);
    end
    check_val("btn_level", btn_level, m_level);
    check_val("overflow", overflow, m_ovf);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step_cyc();
  endtask

  task automatic clear_acc();
    for (int b = 0; b < 8; b++)
      for (int t = 0; t < 4; t++) acc_cnt[b][t] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b1;
    run_cycles(3);
    check_val("rst_evt_valid", evt_valid, 0);
    check_val("rst_evt_btn", evt_btn, 0);
    check_val("rst_evt_type", evt_type, 0);
    check_val("rst_btn_level", btn_level, 0);
    check_val("rst_overflow", overflow, 0);
    rst = 1'b0;
    clear_acc();
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (evt_valid !== 1'b1 && k < 60) begin step_cyc(); k++; end
    check_val(tag, evt_valid, 1);
  endtask

  task automatic wait_level(input int b, input logic v, input string tag);
    int k = 0;
    while (btn_level[b] !== v && k < 60) begin step_cyc(); k++; end
    check_val(tag, btn_level[b], v);
  endtask

  int rem [N];
  int k_lat;

  initial begin
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b1;
    do_reset();

    // Single press: debounce latency then PRESS one cycle later.
    btn_raw[2] = 1'b1;
    k_lat = 0;
    while (btn_level[2] !== 1'b1 && k_lat < 60) begin step_cyc(); k_lat++; end
    check_val("press_level_lat_ok", (k_lat <= DEB*TDIV + 2), 1);
    step_cyc();
    check_val("press_valid", evt_valid, 1);
    check_val("press_btn", evt_btn, 2);
    check_val("press_type", evt_type, 0);
    run_cycles(10);
    check_val("press_count", acc_cnt[2][0], 1);

    // Glitch shorter than the debounce window.
    do_reset();
    btn_raw[0] = 1'b1;
    run_cycles(2*TDIV);
    btn_raw[0] = 1'b0;
    run_cycles(20);
    check_val("glitch_level", btn_level[0], 0);
    check_val("glitch_events", acc_cnt[0][0] + acc_cnt[0][1], 0);

    // Long hold: LONG at 8 ticks, REPEAT at 12/16/20, release at tick 21.
    do_reset();
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, "hold_press_level");
    run_cycles(18*TDIV);
    btn_raw[1] = 1'b0;
    run_cycles(30);
    check_val("hold_press_cnt", acc_cnt[1][0], 1);
    check_val("hold_long_cnt", acc_cnt[1][2], REP_EN ? 1 : 0);
    check_val("hold_repeat_cnt", acc_cnt[1][3], REP_EN ? 3 : 0);
    check_val("hold_release_cnt", acc_cnt[1][1], 1);

    // Simultaneous presses with a stalled consumer.
    do_reset();
    evt_ready = 1'b0;
    btn_raw = 5'b01001;
    wait_valid("rr_first_valid");
    for (int i = 0; i < 10; i++) begin
      step_cyc();
      check_val("rr_stall_btn", evt_btn, 0);
    end
    evt_ready = 1'b1;
    step_cyc();
    check_val("rr_second_valid", evt_valid, 1);
    check_val("rr_second_btn", evt_btn, 3);
    check_val("rr_second_type", evt_type, 0);
    btn_raw = '0;
    run_cycles(30);

    // Press, release, press again while stalled: third event is dropped.
    do_reset();
    evt_ready = 1'b0;
    btn_raw[4] = 1'b1;
    wait_valid("ovf_first_valid");
    check_val("ovf_first_btn", evt_btn, 4);
    btn_raw[4] = 1'b0;
    wait_level(4, 1'b0, "ovf_release_level");
    btn_raw[4] = 1'b1;
    wait_level(4, 1'b1, "ovf_repress_level");
    run_cycles(2);
    check_val("ovf_set", overflow, 1);
    evt_ready = 1'b1;
    step_cyc();
    check_val("ovf_next_btn", evt_btn, 4);
    check_val("ovf_next_type", evt_type, 1);
    run_cycles(20);
    check_val("ovf_sticky", overflow, 1);
    check_val("ovf_press_cnt", acc_cnt[4][0], 1);

    // Reset mid-handshake with the button held.
    do_reset();
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    wait_valid("rstmid_valid");
    rst = 1'b1;
    step_cyc();
    check_val("rstmid_cleared", evt_valid, 0);
    rst = 1'b0;
    k_lat = 0;
    while (evt_valid !== 1'b1 && k_lat < 60) begin step_cyc(); k_lat++; end
    check_val("rstmid_reissue_lat", k_lat, DEB*TDIV + 2);
    check_val("rstmid_btn", evt_btn, 2);
    check_val("rstmid_type", evt_type, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : $urandom_range(12, 150);
        end else begin
          rem[i]--;
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      step_cyc();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 Parameter N_BTN, default 5, number of button inputs (1..8).
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per sample tick (>=2).
REQ-003 Parameter DEB_TICKS, default 10, consecutive differing ticks needed to accept a level change (>=1).
REQ-004 Parameter LONG_TICKS, default 500, held ticks after a press before a LONG event (>=1).
REQ-005 Parameter REP_TICKS, default 100, ticks between REPEAT events after LONG (>=1).
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 btn_raw  in  N_BTN  asynchronous raw button levels, 1 = pressed.
REQ-009 evt_ready  in  1  consumer accepts the event when high with evt_valid.
REQ-010 evt_valid  out  1  event present on evt_btn/evt_type.
REQ-011 evt_btn  out  3  index of the button that produced the event.
REQ-012 evt_type  out  2  0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
REQ-013 btn_level  out  N_BTN  debounced levels.
REQ-014 overflow  out  1  sticky; set when an event is dropped.

Function
REQ-015 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 A free-running counter SHALL pulse tick for one cycle every TICK_DIV cycles; tick is shared by all buttons.
REQ-017 Per button, on tick: synced != btn_level increments deb_cnt; synced == btn_level clears deb_cnt; when deb_cnt == DEB_TICKS-1 and still differing, btn_level flips and deb_cnt clears in the same cycle.
REQ-018 A 0->1 flip of btn_level SHALL post PRESS, a 1->0 flip SHALL post RELEASE, into that button's single pending slot in the flip cycle.
REQ-019 Per button, hold state machine IDLE -> HELD (on PRESS) -> LONGED (after LONG_TICKS ticks in HELD, posts LONG) -> LONGED posts REPEAT every REP_TICKS ticks; any RELEASE returns to IDLE and clears the hold counter.
REQ-020 Posting into a full pending slot SHALL drop the new event and set overflow; exception: if the slot is granted in the same cycle, the new event SHALL occupy it without overflow.
REQ-021 Arbiter: when evt_valid is low, or evt_valid and evt_ready are both high, the pending slot chosen round-robin (search starts at the index after the last granted) SHALL load the output registers on the next edge and its slot SHALL clear.
REQ-022 Grant latency SHALL be one cycle from slot set to evt_valid with no contention; back-to-back events SHALL issue at one per cycle when evt_ready stays high.
REQ-023 While evt_valid is high and evt_ready is low, evt_btn and evt_type SHALL hold stable.
REQ-024 Multiple buttons flipping in the same tick SHALL each post independently; the arbiter SHALL service them in round-robin order.

Reset
REQ-025 On rst: evt_valid=0, evt_btn=0, evt_type=0, btn_level=0, overflow=0, all pending slots empty, all counters 0, all hold FSMs IDLE, round-robin pointer 0.
REQ-026 Asserting rst mid-handshake SHALL discard the presented event; a button held through reset SHALL post PRESS after DEB_TICKS ticks.

Configuration
REQ-027 Macro BTN_EVT_REPEAT_EN defined: hold FSM and LONG/REPEAT events present per REQ-019.
REQ-028 Macro BTN_EVT_REPEAT_EN undefined: no hold FSM or hold counters are built; evt_type is only 0 or 1; LONG_TICKS and REP_TICKS are ignored.

Verification (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8, REP_TICKS=4, macro defined)
REQ-029 btn_raw[2] rises and stays high, evt_ready=1 -> btn_level[2]=1 within 3 ticks plus 2 sync cycles; one PRESS event with evt_btn=2, evt_type=0 the next cycle.
REQ-030 btn_raw[0] glitches high for 2 ticks, then low -> no event, btn_level[0] stays 0.
REQ-031 btn_raw[1] held for 20 ticks after PRESS -> LONG at 8 ticks, then REPEAT at 12, 16, 20 ticks; on release, RELEASE follows.
REQ-032 btn_raw[0] and btn_raw[3] rise in the same cycle with evt_ready=0 for 10 cycles -> evt_valid held with evt_btn=0 stable; after evt_ready=1, the button-3 PRESS follows on the next cycle.
REQ-033 evt_ready=0 while button 4 is pressed, released, and pressed again -> the first PRESS is presented, the RELEASE fills the slot, the second PRESS is dropped, overflow=1 until rst.
REQ-034 rst pulsed while evt_valid=1 and btn_raw[2] is held -> evt_valid=0 the next cycle; a PRESS for button 2 is reissued after 3 ticks.
